// File: rtl/video_timing_pkg.sv
// Shared types and raster-boundary helpers for the video timing generator.
// Provides the 12-bit coordinate type, default 1080p60 timing and region math.
package video_timing_pkg;

    typedef logic [11:0] coord_t;

    // Default raster: 1920x1080 with CEA-861 porches.
    localparam int DEF_H_ACTIVE = 1920;
    localparam int DEF_H_FP     = 88;
    localparam int DEF_H_SYNC   = 44;
    localparam int DEF_H_BP     = 148;
    localparam int DEF_V_ACTIVE = 1080;
    localparam int DEF_V_FP     = 4;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BP     = 36;

    // Registered output bundle of the generator.
    typedef struct packed {
        logic   de;
        logic   hsync;
        logic   vsync;
        logic   sof;
        coord_t x;
        coord_t y;
    } vtg_out_t;

    // Region order on each axis is active, front porch, sync, back porch.
    function automatic coord_t f_total(input int act, input int fp,
                                       input int sync, input int bp);
        return coord_t'(act + fp + sync + bp);
    endfunction

    function automatic coord_t f_sync_start(input int act, input int fp);
        return coord_t'(act + fp);
    endfunction

    function automatic coord_t f_sync_end(input int act, input int fp,
                                          input int sync);
        return coord_t'(act + fp + sync);
    endfunction

endpackage

// File: rtl/video_timing_gen_counter.sv
// vtg_counter: 12-bit wrapping counter with enable, terminal-count flag and
// synchronous load. Ports: clk_i, rst_i, en_i, ld_i, ld_val_i, cnt_o, tc_o.
module vtg_counter
    import video_timing_pkg::*;
#(
    parameter coord_t MAX = 12'd15
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   en_i,
    input  logic   ld_i,
    input  coord_t ld_val_i,
    output coord_t cnt_o,
    output logic   tc_o
);

    coord_t cnt_q;
    coord_t cnt_d;

    assign tc_o  = (cnt_q == MAX);
    assign cnt_o = cnt_q;

    // Load has priority over counting so a genlock event always wins.
    always_comb begin
        cnt_d = cnt_q;
        if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 12'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing source producing de/hsync/vsync, pixel x/y
// and a start-of-frame pulse. Ports: clk, reset (async, active-high), enable,
// de, hsync, vsync, x, y, sof; with VTG_GENLOCK_EN defined also lock_vsync
// (external vsync input) and lock_err (frame re-alignment pulse).
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
`ifdef VTG_GENLOCK_EN
    input  logic        lock_vsync,
    output logic        lock_err,
`endif
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        sof
);

    localparam coord_t H_TOTAL  = f_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam coord_t HS_START = f_sync_start(H_ACTIVE, H_FP);
    localparam coord_t HS_END   = f_sync_end(H_ACTIVE, H_FP, H_SYNC);
    localparam coord_t V_TOTAL  = f_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam coord_t VS_START = f_sync_start(V_ACTIVE, V_FP);
    localparam coord_t VS_END   = f_sync_end(V_ACTIVE, V_FP, V_SYNC);
    localparam coord_t H_ACT    = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT    = coord_t'(V_ACTIVE);

    localparam vtg_out_t OUT_RST = '{
        de:    1'b0,
        hsync: ~HS_POL,
        vsync: ~VS_POL,
        sof:   1'b0,
        x:     '0,
        y:     '0
    };

    coord_t   h_cnt;
    coord_t   v_cnt;
    logic     h_tc;
    logic     v_tc_unused;
    logic     lock_ld;
    vtg_out_t out_q;
    vtg_out_t out_d;

`ifdef VTG_GENLOCK_EN
    // Expected counter position one cycle before the natural vsync start.
    localparam coord_t VS_PRE = VS_START - 12'd1;

    logic lock_q;
    logic lock_err_q;
    logic lock_err_d;

    assign lock_ld    = lock_vsync & ~lock_q & enable;
    assign lock_err_d = lock_ld & ~(h_tc & (v_cnt == VS_PRE));
    assign lock_err   = lock_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q     <= 1'b0;
            lock_err_q <= 1'b0;
        end else begin
            lock_q     <= lock_vsync;
            lock_err_q <= lock_err_d;
        end
    end
`else
    assign lock_ld = 1'b0;
`endif

    vtg_counter #(
        .MAX(H_TOTAL - 12'd1)
    ) u_h_cnt (
        .clk_i    (clk),
        .rst_i    (reset),
        .en_i     (enable),
        .ld_i     (lock_ld),
        .ld_val_i ('0),
        .cnt_o    (h_cnt),
        .tc_o     (h_tc)
    );

    // Vertical advances on the last pixel of each line.
    vtg_counter #(
        .MAX(V_TOTAL - 12'd1)
    ) u_v_cnt (
        .clk_i    (clk),
        .rst_i    (reset),
        .en_i     (enable & h_tc),
        .ld_i     (lock_ld),
        .ld_val_i (VS_START),
        .cnt_o    (v_cnt),
        .tc_o     (v_tc_unused)
    );

    logic act;
    logic hs_act;
    logic vs_act;

    assign act    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_act = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign vs_act = (v_cnt >= VS_START) && (v_cnt < VS_END);

    // While frozen, de/sof drop and everything else keeps its last value.
    always_comb begin
        out_d     = out_q;
        out_d.de  = 1'b0;
        out_d.sof = 1'b0;
        if (enable) begin
            out_d.de    = act;
            out_d.sof   = act && (h_cnt == '0) && (v_cnt == '0);
            out_d.hsync = hs_act ? HS_POL : ~HS_POL;
            out_d.vsync = vs_act ? VS_POL : ~VS_POL;
            if (act) begin
                out_d.x = h_cnt;
                out_d.y = v_cnt;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= OUT_RST;
        end else begin
            out_q <= out_d;
        end
    end

    assign de    = out_q.de;
    assign hsync = out_q.hsync;
    assign vsync = out_q.vsync;
    assign sof   = out_q.sof;
    assign x     = out_q.x;
    assign y     = out_q.y;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen using a 16x8 raster (8 active x 4 lines).
// Genlock steps are included when VTG_GENLOCK_EN is defined.
module tb_video_timing_gen;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic [11:0] x;
    logic [11:0] y;
    logic        sof;
`ifdef VTG_GENLOCK_EN
    logic        lock_vsync;
    logic        lock_err;
`endif

    int n_chk;
    int n_fail;

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
`ifdef VTG_GENLOCK_EN
        .lock_vsync (lock_vsync),
        .lock_err   (lock_err),
`endif
        .de         (de),
        .hsync      (hsync),
        .vsync      (vsync),
        .x          (x),
        .y          (y),
        .sof        (sof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    logic        de_a  [1:129];
    logic        hs_a  [1:129];
    logic        vs_a  [1:129];
    logic        sof_a [1:129];
    logic [11:0] x_a   [1:129];
    logic [11:0] y_a   [1:129];

    initial begin
        int n;
        int m;
        int cnt_de;
        int cnt_hs;
        int cnt_vs;
        int cnt_sof;
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b1;
        enable = 1'b1;
`ifdef VTG_GENLOCK_EN
        lock_vsync = 1'b0;
`endif
        #12;
        chk("rst_de", de, 0);
        chk("rst_sof", sof, 0);
        chk("rst_hs", hsync, 0);
        chk("rst_vs", vsync, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
`ifdef VTG_GENLOCK_EN
        chk("rst_lock_err", lock_err, 0);
`endif
        tick();
        reset = 1'b0;

        // First frame: sample s shows raster index s-1.
        for (int s = 1; s <= 129; s++) begin
            tick();
            de_a[s]  = de;
            hs_a[s]  = hsync;
            vs_a[s]  = vsync;
            sof_a[s] = sof;
            x_a[s]   = x;
            y_a[s]   = y;
        end
        chk("first_de", de_a[1], 1);
        chk("first_sof", sof_a[1], 1);
        chk("first_x", x_a[1], 0);
        chk("first_y", y_a[1], 0);
        chk("last_act_x", x_a[8], 7);
        chk("fp_de", de_a[9], 0);
        chk("fp_x_held", x_a[9], 7);
        chk("hs_before", hs_a[10], 0);
        chk("hs_rise", hs_a[11], 1);
        chk("hs_last", hs_a[13], 1);
        chk("hs_fall", hs_a[14], 0);
        chk("l1_x", x_a[18], 1);
        chk("l1_y", y_a[18], 1);
        chk("l3_end_de", de_a[64], 0);
        chk("l3_end_x", x_a[64], 7);
        chk("l3_end_y", y_a[64], 3);
        chk("vs_before", vs_a[80], 0);
        chk("vs_rise", vs_a[81], 1);
        chk("vs_rise_hs", hs_a[81], 0);
        chk("vs_last", vs_a[112], 1);
        chk("vs_fall", vs_a[113], 0);
        chk("sof_period", sof_a[129], 1);
        cnt_de  = 0;
        cnt_hs  = 0;
        cnt_vs  = 0;
        cnt_sof = 0;
        for (int s = 1; s <= 128; s++) begin
            cnt_de  += int'(de_a[s]);
            cnt_hs  += int'(hs_a[s]);
            cnt_vs  += int'(vs_a[s]);
            cnt_sof += int'(sof_a[s]);
        end
        chk("de_per_frame", cnt_de, 32);
        chk("hs_per_frame", cnt_hs, 24);
        chk("vs_per_frame", cnt_vs, 32);
        chk("sof_per_frame", cnt_sof, 1);

        // Freeze at pixel (5,2) for 10 cycles.
        n = 0;
        while (!(de === 1'b1 && x == 12'd5 && y == 12'd2) && n < 300) begin
            tick();
            n++;
        end
        chk("ticks_to_5_2", n, 37);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("frz_de", de, 0);
            chk("frz_sof", sof, 0);
            chk("frz_x", x, 5);
            chk("frz_y", y, 2);
        end
        enable = 1'b1;
        tick();
        chk("resume_de", de, 1);
        chk("resume_x", x, 6);
        chk("resume_y", y, 2);
        m = 0;
        do begin
            tick();
            m++;
        end while (sof !== 1'b1 && m < 300);
        chk("resume_to_sof", m, 90);
        chk("frame_len_ext", n + 10 + 1 + m, 138);

        // Reset in the middle of the frame.
        n = 0;
        while (!(de === 1'b1 && x == 12'd3 && y == 12'd1) && n < 300) begin
            tick();
            n++;
        end
        chk("ticks_to_3_1", n, 19);
        reset = 1'b1;
        #1;
        chk("mid_rst_de", de, 0);
        chk("mid_rst_hs", hsync, 0);
        chk("mid_rst_vs", vsync, 0);
        chk("mid_rst_x", x, 0);
        chk("mid_rst_y", y, 0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rel_sof_pre", sof, 0);
        tick();
        chk("rel_sof", sof, 1);
        chk("rel_de", de, 1);
        chk("rel_x", x, 0);
        chk("rel_y", y, 0);

`ifdef VTG_GENLOCK_EN
        // Misaligned lock edge with the counter at (4,2).
        n = 0;
        while (!(de === 1'b1 && x == 12'd3 && y == 12'd2) && n < 300) begin
            tick();
            n++;
        end
        chk("ticks_to_3_2", n, 35);
        lock_vsync = 1'b1;
        tick();
        chk("gl_err", lock_err, 1);
        chk("gl_vs_pre", vsync, 0);
        chk("gl_x", x, 4);
        lock_vsync = 1'b0;
        tick();
        chk("gl_vs", vsync, 1);
        chk("gl_err_clr", lock_err, 0);
        chk("gl_de", de, 0);
        m = 0;
        do begin
            tick();
            m++;
        end while (sof !== 1'b1 && m < 300);
        chk("gl_to_sof", m, 48);

        // Lock edges aligned to the natural vsync start.
        cnt_sof = 0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 78; i++) begin
                tick();
                cnt_sof += int'(lock_err);
            end
            lock_vsync = 1'b1;
            tick();
            chk("al_err", lock_err, 0);
            chk("al_vs_pre", vsync, 0);
            lock_vsync = 1'b0;
            tick();
            chk("al_vs", vsync, 1);
            for (int i = 0; i < 47; i++) begin
                tick();
                cnt_sof += int'(lock_err);
            end
            tick();
            chk("al_sof", sof, 1);
        end
        chk("al_err_total", cnt_sof, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
